// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment display blocks.
package seg_pkg;

    typedef enum logic {BLANK, SHOW} seg_state_e;

    localparam logic [3:0] BLANK_CODE     = 4'hF;
    localparam int         SEG_MAX_DIGITS = 16;

    // Callers zero-extend their packed BCD word to SEG_MAX_DIGITS nibbles.
    function automatic logic [3:0] digit_of(input logic [4*SEG_MAX_DIGITS-1:0] pv,
                                            input logic [3:0]                  idx);
        return pv[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// BLANK/SHOW slot timer: walks the digit index and strobes slot_end / digit_wrap.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 2,
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             in_show,
    output logic [IDX_W-1:0] idx,
    output logic             slot_end,
    output logic             digit_wrap
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    seg_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BLANK;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cnt_n      = cnt + CNT_W'(1);
        slot_end   = 1'b0;
        digit_wrap = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    slot_end = 1'b1;
                    state_n  = SHOW;
                    cnt_n    = '0;
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    slot_end   = 1'b1;
                    digit_wrap = (idx == IDX_LAST);
                    state_n    = BLANK;
                    cnt_n      = '0;
                    idx_n      = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end
            end
            default: state_n = BLANK;
        endcase
    end

    assign in_show = (state == SHOW);

endmodule

// File: rtl/seg_scan_driver.sv
// Double-buffered N-digit 7-segment scan driver; all outputs registered.
// Define SEG_SCAN_LZ_SUPPRESS_EN to blank leading zeros (digit 0 is always shown).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic [3:0]              bin,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int W     = 4 * NUM_DIGITS;

    logic             in_show, slot_end, digit_wrap;
    logic [IDX_W-1:0] idx;

    seg_scan_timer #(
        .NUM_DIGITS(NUM_DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .in_show   (in_show),
        .idx       (idx),
        .slot_end  (slot_end),
        .digit_wrap(digit_wrap)
    );

    // High during the timer's first BLANK cycle of a digit / of digit 0.
    // Outputs lag the timer by one register stage.
    logic new_digit, new_frame;

    logic [W-1:0]                  shadow, pend_buf, shadow_n;
    logic                          pending;
    logic [4*SEG_MAX_DIGITS-1:0]   shadow_ext;
    logic [3:0]                    idx4;
    logic [3:0]                    code_n;

    always_comb begin
        shadow_n = shadow;
        if (new_frame) begin
            if (load)
                shadow_n = value;
            else if (pending)
                shadow_n = pend_buf;
        end

        shadow_ext       = '0;
        shadow_ext[W-1:0] = shadow_n;
        idx4             = '0;
        idx4[IDX_W-1:0]  = idx;
        code_n           = digit_of(shadow_ext, idx4);
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
        if (idx4 != 4'd0 && (shadow_ext >> {idx4, 2'b00}) == '0)
            code_n = BLANK_CODE;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            new_digit   <= 1'b1;
            new_frame   <= 1'b1;
            shadow      <= '0;
            pend_buf    <= '0;
            pending     <= 1'b0;
            an          <= '0;
            bin         <= 4'h0;
            frame_start <= 1'b0;
        end else begin
            new_digit   <= slot_end && in_show;
            new_frame   <= digit_wrap;
            shadow      <= shadow_n;
            if (new_frame) begin
                pending <= 1'b0;
            end else if (load) begin
                pend_buf <= value;
                pending  <= 1'b1;
            end
            frame_start <= new_frame;
            an          <= '0;
            if (in_show)
                an[idx] <= 1'b1;
            if (new_digit)
                bin <= code_n;
        end
    end

endmodule
